mfm_sector_reader: RTL and testbench

//  Sector-level parser downstream of the MFM byte decoder. Consumes the decoded byte/mark/CRC

---
 rtl/mfm_pkg.sv | 35 +++
 rtl/mfm_am_sync.sv | 49 ++++
 rtl/mfm_sector_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_mfm_sector_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfm_pkg.sv
//------------------------------------------------------------------------------
// Module   : mfm_pkg
// Purpose  : Shared constants, FSM encodings and sector-size helper for the
//            MFM sector reader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mfm_pkg;

   localparam logic [7:0] AM_SYNC = 8'hA1;
   localparam logic [7:0] AM_IDAM = 8'hFE;
   localparam logic [7:0] AM_DAM  = 8'hFB;
   localparam logic [7:0] AM_DDAM = 8'hF8;

   localparam int STATUS_NOT_FOUND = 0;
   localparam int STATUS_ID_CRC    = 1;
   localparam int STATUS_DATA_CRC  = 2;
   localparam int STATUS_DEL_SIZE  = 3;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SEARCH   = 3'd1;
   localparam logic [2:0] ST_ID_FIELD = 3'd2;
   localparam logic [2:0] ST_WAIT_DAM = 3'd3;
   localparam logic [2:0] ST_DATA     = 3'd4;
   localparam logic [2:0] ST_DATA_CRC = 3'd5;
   localparam logic [2:0] ST_DONE     = 3'd6;

   function automatic logic [11:0] sector_size(input logic [1:0] n);
      return 12'd128 << n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mfm_am_sync.sv
//------------------------------------------------------------------------------
// Module   : mfm_am_sync
// Purpose  : Counts consecutive A1 marks (saturating at 3) and classifies the
//            first non-mark byte after a full sync as IDAM/DAM/DDAM/other.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mfm_am_sync
   import mfm_pkg::*;
(
   input  logic       clk,
   input  logic       reset_l,
   input  logic       i_valid,
   input  logic       i_mark,
   input  logic [7:0] i_data,
   output logic       o_is_idam,
   output logic       o_is_dam,
   output logic       o_is_ddam,
   output logic       o_is_other
);

   logic [1:0] r_mark_cnt;
   logic       w_type_stb;

   // Any non-mark byte ends the sync run, including the type byte itself.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_mark_cnt <= 2'd0;
      end else if (i_valid) begin
         if (i_mark) begin
            if (r_mark_cnt != 2'd3)
               r_mark_cnt <= r_mark_cnt + 2'd1;
         end else begin
            r_mark_cnt <= 2'd0;
         end
      end
   end

   assign w_type_stb = i_valid && !i_mark && (r_mark_cnt == 2'd3);
   assign o_is_idam  = w_type_stb && (i_data == AM_IDAM);
   assign o_is_dam   = w_type_stb && (i_data == AM_DAM);
   assign o_is_ddam  = w_type_stb && (i_data == AM_DDAM);
   assign o_is_other = w_type_stb && (i_data != AM_IDAM) && (i_data != AM_DAM) &&
                       (i_data != AM_DDAM);

endmodule

`default_nettype wire

// File: rtl/mfm_sector_reader.sv
//------------------------------------------------------------------------------
// Module   : mfm_sector_reader
// Purpose  : Finds the ID field matching a commanded C/H/R in the decoded MFM
//            stream and streams out that sector's data field.
//            Option macro: MFM_DELETED_DAM_EN (accept F8 deleted-data marks).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mfm_sector_reader
   import mfm_pkg::*;
#(
   parameter int MAX_REVS   = 2,
   parameter int DAM_WINDOW = 43,
   parameter int MAX_N      = 3
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic [7:0]  in_data,
   input  logic        in_mark,
   input  logic        in_valid,
   input  logic        in_crc_zero,
   input  logic        index_l,
   input  logic        start,
   input  logic [7:0]  tgt_track,
   input  logic [7:0]  tgt_head,
   input  logic [7:0]  tgt_sector,
   output logic        busy,
   output logic        done,
   output logic [3:0]  status,
   output logic [1:0]  size_code,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_last,
   output logic [10:0] out_addr
);

   localparam logic [7:0]  c_max_revs = 8'(MAX_REVS);
   localparam logic [7:0]  c_max_n    = 8'(MAX_N);
   localparam logic [10:0] c_dam_win  = 11'(DAM_WINDOW);

   logic [2:0]  r_state, w_next, w_next_byte;
   logic [10:0] r_cnt;
   logic [7:0]  r_tgt_c, r_tgt_h, r_tgt_r;
   logic [7:0]  r_id_c, r_id_h, r_id_r, r_id_n;
   logic [7:0]  r_revs;
   logic [2:0]  r_idx_sync;
   logic [3:0]  r_status;
   logic [1:0]  r_size;
   logic [7:0]  r_out_data;
   logic        r_out_valid, r_out_last;
   logic [10:0] r_out_addr;

   logic w_is_idam, w_is_dam, w_is_ddam, w_is_other;
   logic w_start_acc, w_searching, w_idx_fall, w_revs_hit, w_set_nf;
   logic w_id_last, w_chr_match, w_n_ok, w_gap_byte, w_win_expire;
   logic w_data_last, w_crc_last, w_dam_ok, w_dam_reject;

   mfm_am_sync u_am_sync (
      .clk        (clk),
      .reset_l    (reset_l),
      .i_valid    (in_valid),
      .i_mark     (in_mark),
      .i_data     (in_data),
      .o_is_idam  (w_is_idam),
      .o_is_dam   (w_is_dam),
      .o_is_ddam  (w_is_ddam),
      .o_is_other (w_is_other)
   );

   assign w_start_acc  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_searching  = (r_state == ST_SEARCH) || (r_state == ST_WAIT_DAM);
   assign w_idx_fall   = r_idx_sync[2] && !r_idx_sync[1];
   assign w_revs_hit   = w_idx_fall && w_searching && ((r_revs + 8'd1) >= c_max_revs);
   assign w_id_last    = (r_state == ST_ID_FIELD) && in_valid && (r_cnt == 11'd5);
   assign w_chr_match  = (r_id_c == r_tgt_c) && (r_id_h == r_tgt_h) && (r_id_r == r_tgt_r);
   assign w_n_ok       = (r_id_n <= c_max_n);
   assign w_gap_byte   = in_valid && !in_mark && !(w_is_idam || w_is_dam || w_is_ddam || w_is_other);
   assign w_win_expire = (r_state == ST_WAIT_DAM) && w_gap_byte && ((r_cnt + 11'd1) == c_dam_win);
   assign w_data_last  = ({1'b0, r_cnt} == (sector_size(r_size) - 12'd1));
   assign w_crc_last   = (r_state == ST_DATA_CRC) && in_valid && (r_cnt == 11'd1);

`ifdef MFM_DELETED_DAM_EN
   assign w_dam_ok     = w_is_dam || w_is_ddam;
   assign w_dam_reject = w_is_idam || w_is_other;
`else
   assign w_dam_ok     = w_is_dam;
   assign w_dam_reject = w_is_idam || w_is_ddam || w_is_other;
`endif

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next_byte = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: w_next_byte = w_start_acc ? ST_SEARCH : ST_IDLE;
         ST_SEARCH:        if (w_is_idam) w_next_byte = ST_ID_FIELD;
         ST_ID_FIELD: begin
            if (w_id_last) begin
               if (!in_crc_zero)
                  w_next_byte = ST_SEARCH;
               else if (w_chr_match)
                  w_next_byte = w_n_ok ? ST_WAIT_DAM : ST_DONE;
               else
                  w_next_byte = ST_SEARCH;
            end
         end
         ST_WAIT_DAM: begin
            if (w_dam_ok)
               w_next_byte = ST_DATA;
            else if (w_dam_reject || w_win_expire)
               w_next_byte = ST_SEARCH;
         end
         ST_DATA:     if (in_valid && w_data_last) w_next_byte = ST_DATA_CRC;
         ST_DATA_CRC: if (w_crc_last) w_next_byte = ST_DONE;
         default:     w_next_byte = ST_IDLE;
      endcase
   end

   // The byte wins; not-found only fires if that byte leaves us still searching.
   assign w_set_nf = w_revs_hit && ((w_next_byte == ST_SEARCH) || (w_next_byte == ST_WAIT_DAM));
   assign w_next   = w_set_nf ? ST_DONE : w_next_byte;

   always_comb begin
      busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
      done = (r_state == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l)
         r_idx_sync <= 3'b111;
      else
         r_idx_sync <= {r_idx_sync[1:0], index_l};
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_cnt       <= 11'd0;
         r_tgt_c     <= 8'd0;
         r_tgt_h     <= 8'd0;
         r_tgt_r     <= 8'd0;
         r_id_c      <= 8'd0;
         r_id_h      <= 8'd0;
         r_id_r      <= 8'd0;
         r_id_n      <= 8'd0;
         r_revs      <= 8'd0;
         r_status    <= 4'd0;
         r_size      <= 2'd0;
         r_out_data  <= 8'd0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_addr  <= 11'd0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;

         // One counter serves ID byte index, DAM gap, data address and CRC index.
         if (w_next != r_state)
            r_cnt <= 11'd0;
         else if (in_valid && ((r_state == ST_ID_FIELD) || (r_state == ST_DATA) ||
                               (r_state == ST_DATA_CRC)))
            r_cnt <= r_cnt + 11'd1;
         else if ((r_state == ST_WAIT_DAM) && w_gap_byte)
            r_cnt <= r_cnt + 11'd1;

         if (w_start_acc) begin
            r_tgt_c  <= tgt_track;
            r_tgt_h  <= tgt_head;
            r_tgt_r  <= tgt_sector;
            r_status <= 4'd0;
            r_size   <= 2'd0;
            r_revs   <= 8'd0;
         end else if (w_idx_fall && w_searching) begin
            r_revs <= r_revs + 8'd1;
         end

         if ((r_state == ST_ID_FIELD) && in_valid) begin
            case (r_cnt)
               11'd0:   r_id_c <= in_data;
               11'd1:   r_id_h <= in_data;
               11'd2:   r_id_r <= in_data;
               11'd3:   r_id_n <= in_data;
               default: ;
            endcase
         end

         if (w_id_last && !in_crc_zero)
            r_status[STATUS_ID_CRC] <= 1'b1;
         if (w_id_last && in_crc_zero && w_chr_match) begin
            if (w_n_ok)
               r_size <= r_id_n[1:0];
            else
               r_status[STATUS_DEL_SIZE] <= 1'b1;
         end

`ifdef MFM_DELETED_DAM_EN
         if ((r_state == ST_WAIT_DAM) && w_is_ddam)
            r_status[STATUS_DEL_SIZE] <= 1'b1;
`endif

         if ((r_state == ST_DATA) && in_valid) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
            r_out_addr  <= r_cnt;
            r_out_last  <= w_data_last;
         end

         if (w_crc_last)
            r_status[STATUS_DATA_CRC] <= !in_crc_zero;
         if (w_set_nf)
            r_status[STATUS_NOT_FOUND] <= 1'b1;
      end
   end

   assign status    = r_status;
   assign size_code = r_size;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_addr  = r_out_addr;

endmodule

`default_nettype wire

// File: tb/tb_mfm_sector_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_mfm_sector_reader
// Purpose  : Directed self-checking bench for mfm_sector_reader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mfm_sector_reader;
   import mfm_pkg::*;

   logic        clk = 1'b0;
   logic        reset_l = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_mark = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_crc_zero = 1'b0;
   logic        index_l = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  tgt_track = 8'd0;
   logic [7:0]  tgt_head = 8'd0;
   logic [7:0]  tgt_sector = 8'd0;
   logic        busy, done, out_valid, out_last;
   logic [3:0]  status;
   logic [1:0]  size_code;
   logic [7:0]  out_data;
   logic [10:0] out_addr;

   int n_checks = 0;
   int n_errors = 0;

   int mon_out = 0, mon_bad = 0, mon_last = 0, mon_last_addr = 0;
   int mon_done = 0, mon_done_status = 0, mon_done_busy = 0, mon_seq = 0;
   int b_out, b_done, b_last;

   mfm_sector_reader dut (
      .clk         (clk),
      .reset_l     (reset_l),
      .in_data     (in_data),
      .in_mark     (in_mark),
      .in_valid    (in_valid),
      .in_crc_zero (in_crc_zero),
      .index_l     (index_l),
      .start       (start),
      .tgt_track   (tgt_track),
      .tgt_head    (tgt_head),
      .tgt_sector  (tgt_sector),
      .busy        (busy),
      .done        (done),
      .status      (status),
      .size_code   (size_code),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_addr    (out_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_data(input int i);
      if (i >= 10 && i <= 12)
         return AM_SYNC;
      return 8'((i * 7) + 3);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Output monitor: verifies each data byte against its expected address/value.
   always @(negedge clk) begin
      if (!reset_l) begin
         mon_seq = 0;
      end else begin
         if (out_valid) begin
            mon_out++;
            if (out_addr != 11'(mon_seq) || out_data != exp_data(mon_seq))
               mon_bad++;
            if (out_last) begin
               mon_last++;
               mon_last_addr = int'(out_addr);
               mon_seq = 0;
            end else begin
               mon_seq++;
            end
         end
         if (done) begin
            mon_done++;
            mon_done_status = int'(status);
            mon_done_busy = int'(busy);
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic m, input logic cz);
      @(posedge clk); #1;
      in_data = d; in_mark = m; in_crc_zero = cz; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_mark = 1'b0; in_crc_zero = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) send(8'h4E, 1'b0, 1'b0);
   endtask

   task automatic sync3();
      for (int i = 0; i < 3; i++) send(AM_SYNC, 1'b1, 1'b0);
   endtask

   task automatic id_field(input logic [7:0] c, input logic [7:0] h, input logic [7:0] r,
                           input logic [7:0] n, input logic good);
      sync3();
      send(AM_IDAM, 1'b0, 1'b0);
      send(c, 1'b0, 1'b0);
      send(h, 1'b0, 1'b0);
      send(r, 1'b0, 1'b0);
      send(n, 1'b0, 1'b0);
      send(8'h12, 1'b0, 1'b0);
      send(8'h34, 1'b0, good);
   endtask

   task automatic data_field(input logic [7:0] mk, input int n, input logic good);
      sync3();
      send(mk, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) send(exp_data(i), (i >= 10 && i <= 12), 1'b0);
      send(8'h56, 1'b0, 1'b0);
      send(8'h78, 1'b0, good);
   endtask

   task automatic index_pulse();
      @(posedge clk); #1 index_l = 1'b0;
      repeat (4) @(posedge clk);
      #1 index_l = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic command(input logic [7:0] c, input logic [7:0] h, input logic [7:0] r);
      @(posedge clk); #1;
      tgt_track = c; tgt_head = h; tgt_sector = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic snap();
      b_out = mon_out; b_done = mon_done; b_last = mon_last;
   endtask

   task automatic settle();
      repeat (12) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (4) @(posedge clk);
      #1 reset_l = 1'b1;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_status", int'(status), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_size", int'(size_code), 0);

      // Normal 512-byte read; a second start mid-search must be ignored.
      snap();
      command(8'd5, 8'd0, 8'd3);
      check("t1_busy", int'(busy), 1);
      gap(10);
      id_field(8'd5, 8'd0, 8'd3, 8'd2, 1'b1);
      command(8'd5, 8'd0, 8'd9);
      gap(20);
      data_field(AM_DAM, 512, 1'b1);
      gap(4);
      settle();
      check("t1_count", mon_out - b_out, 512);
      check("t1_last", mon_last - b_last, 1);
      check("t1_last_addr", mon_last_addr, 511);
      check("t1_done", mon_done - b_done, 1);
      check("t1_status", mon_done_status, 0);
      check("t1_busy_at_done", mon_done_busy, 0);
      check("t1_size", int'(size_code), 2);
      check("t1_busy_end", int'(busy), 0);

      // Data CRC failure.
      snap();
      command(8'd5, 8'd0, 8'd3);
      gap(10);
      id_field(8'd5, 8'd0, 8'd3, 8'd2, 1'b1);
      gap(20);
      data_field(AM_DAM, 512, 1'b0);
      gap(4);
      settle();
      check("t2_count", mon_out - b_out, 512);
      check("t2_done", mon_done - b_done, 1);
      check("t2_status", mon_done_status, 4);

      // Sector not present: two index revolutions.
      snap();
      command(8'd5, 8'd0, 8'd3);
      gap(5);
      id_field(8'd5, 8'd0, 8'd2, 8'd2, 1'b1);
      gap(10);
      index_pulse();
      check("t3_busy_mid", int'(busy), 1);
      id_field(8'd5, 8'd0, 8'd4, 8'd2, 1'b1);
      gap(10);
      index_pulse();
      settle();
      check("t3_count", mon_out - b_out, 0);
      check("t3_done", mon_done - b_done, 1);
      check("t3_status", mon_done_status, 1);

      // Bad-CRC ID first, then a good one with 256-byte data.
      snap();
      command(8'd5, 8'd0, 8'd3);
      id_field(8'd5, 8'd0, 8'd3, 8'd1, 1'b0);
      gap(10);
      id_field(8'd5, 8'd0, 8'd3, 8'd1, 1'b1);
      gap(20);
      data_field(AM_DAM, 256, 1'b1);
      gap(4);
      settle();
      check("t4_count", mon_out - b_out, 256);
      check("t4_last_addr", mon_last_addr, 255);
      check("t4_status", mon_done_status, 2);
      check("t4_size", int'(size_code), 1);

      // DAM too late: match dropped, picked up on the next revolution.
      snap();
      command(8'd5, 8'd0, 8'd3);
      id_field(8'd5, 8'd0, 8'd3, 8'd0, 1'b1);
      gap(50);
      data_field(AM_DAM, 128, 1'b1);
      gap(5);
      check("t5_no_out", mon_out - b_out, 0);
      check("t5_busy_mid", int'(busy), 1);
      index_pulse();
      gap(5);
      id_field(8'd5, 8'd0, 8'd3, 8'd0, 1'b1);
      gap(20);
      data_field(AM_DAM, 128, 1'b1);
      gap(4);
      settle();
      check("t5_count", mon_out - b_out, 128);
      check("t5_done", mon_done - b_done, 1);
      check("t5_status", mon_done_status, 0);

      // Deleted data mark.
      snap();
      command(8'd5, 8'd0, 8'd3);
      id_field(8'd5, 8'd0, 8'd3, 8'd0, 1'b1);
      gap(20);
      data_field(AM_DDAM, 128, 1'b1);
      gap(5);
      index_pulse();
      index_pulse();
      settle();
      check("t6_done", mon_done - b_done, 1);
`ifdef MFM_DELETED_DAM_EN
      check("t6_count", mon_out - b_out, 128);
      check("t6_status", mon_done_status, 8);
`else
      check("t6_count", mon_out - b_out, 0);
      check("t6_status", mon_done_status, 1);
`endif

      // Size code above MAX_N on a matching ID.
      snap();
      command(8'd5, 8'd0, 8'd3);
      id_field(8'd5, 8'd0, 8'd3, 8'd4, 1'b1);
      settle();
      check("t7_done", mon_done - b_done, 1);
      check("t7_status", mon_done_status, 8);
      check("t7_count", mon_out - b_out, 0);

      // Asynchronous reset mid-transfer.
      snap();
      command(8'd5, 8'd0, 8'd3);
      id_field(8'd5, 8'd0, 8'd3, 8'd2, 1'b1);
      gap(20);
      sync3();
      send(AM_DAM, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) send(exp_data(i), (i >= 10 && i <= 12), 1'b0);
      check("t8_addr_pre", int'(out_addr), 99);
      #3 reset_l = 1'b0;
      #1;
      check("t8_busy", int'(busy), 0);
      check("t8_valid", int'(out_valid), 0);
      check("t8_addr", int'(out_addr), 0);
      check("t8_data", int'(out_data), 0);
      check("t8_status", int'(status), 0);
      check("t8_size", int'(size_code), 0);
      @(posedge clk); #1 reset_l = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("t8_no_done", mon_done - b_done, 0);
      check("data_errors", mon_bad, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
